// File: rtl/rom_sequencer.sv
// Address sequencer for a synchronous pattern ROM feeding the hex display path.
// Hides ROM read latency and holds the last fetched word stable between captures.
module rom_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              run,
    input  logic              step,
    input  logic              restart,
    input  logic              dir,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] value,
    output logic              value_valid,
    output logic              busy
);

    localparam logic [1:0] S_PRIME = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_IDLE  = 2'd2;

    localparam logic [2:0] LAT_CNT = 3'(ROM_LAT);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_value;
    logic              r_valid;
    logic              r_busy;
    logic              r_pend;
    logic [2:0]        r_cnt;

    logic              w_event;
    logic [ADDR_W-1:0] w_next;

    assign w_event = (run & tick) | (~run & step);

    // Bounds are checked before stepping, so an address left outside a shrunken
    // range is pulled back in rather than wrapping through 0 or the top.
    always_comb begin
        w_next = lo;
        if (lo <= hi) begin
            if (!dir) begin
                w_next = (r_addr >= hi) ? lo : r_addr + ADDR_W'(1);
            end else begin
                w_next = (r_addr <= lo) ? hi : r_addr - ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PRIME;
            r_addr  <= '0;
            r_value <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_valid <= 1'b0;
            if (restart) begin
                r_state <= S_FETCH;
                r_addr  <= lo;
                r_cnt   <= LAT_CNT;
                r_pend  <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    S_PRIME: begin
                        r_addr  <= lo;
                        r_cnt   <= LAT_CNT;
                        r_state <= S_FETCH;
                        if (w_event) begin
                            r_pend <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        r_cnt <= r_cnt - 3'd1;
                        if (w_event) begin
                            r_pend <= 1'b1;
                        end
                        if (r_cnt == 3'd1) begin
                            r_value <= rom_q;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    S_IDLE: begin
                        if (w_event || r_pend) begin
                            r_addr  <= w_next;
                            r_cnt   <= LAT_CNT;
                            r_pend  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                    default: begin
                        r_state <= S_PRIME;
                        r_busy  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign rom_addr    = r_addr;
    assign value       = r_value;
    assign value_valid = r_valid;
    assign busy        = r_busy;

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: Gray-code ROM with one-cycle registered read,
// plus a transaction-timed reference model of the sequencer.
module tb_rom_sequencer;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        run;
    logic        step;
    logic        restart;
    logic        dir;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [3:0]  rom_addr;
    logic [15:0] rom_q;
    logic [15:0] value;
    logic        value_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [16];

    rom_sequencer #(.ADDR_W(4), .DATA_W(16), .ROM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .step(step),
        .restart(restart), .dir(dir), .lo(lo), .hi(hi),
        .rom_addr(rom_addr), .rom_q(rom_q), .value(value),
        .value_valid(value_valid), .busy(busy)
    );

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'(i ^ (i >> 1));
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered address stage plus this output register gives the two-edge read latency.
    always @(posedge clk) rom_q <= rom[rom_addr];

    // Reference model: tracks each fetch by the cycle number at which its word is due.
    int          mCyc    = 0;
    int          mDoneAt = 0;
    bit          mPrimed = 0;
    bit          mPend   = 0;
    bit          mEvent;
    logic [3:0]  mAddr   = 0;
    logic [15:0] mValue  = 0;
    logic        mValid  = 0;
    logic        mBusy   = 1;

    function automatic logic [3:0] nextAddr(input logic [3:0] a);
        int ia = a, ilo = lo, ihi = hi;
        if (ilo > ihi) return lo;
        if (!dir) return (ia >= ihi) ? lo : 4'(ia + 1);
        return (ia <= ilo) ? hi : 4'(ia - 1);
    endfunction

    always @(posedge clk) begin
        mCyc++;
        mValid = 1'b0;
        mEvent = (run && tick) || (!run && step);
        if (rst) begin
            mPrimed = 0; mPend = 0; mAddr = 0; mValue = 0; mBusy = 1;
        end else if (restart || !mPrimed) begin
            mPend   = restart ? 1'b0 : (mPend | mEvent);
            mPrimed = 1;
            mAddr   = lo;
            mDoneAt = mCyc + LAT;
            mBusy   = 1;
        end else if (mBusy) begin
            if (mEvent) mPend = 1;
            if (mCyc == mDoneAt) begin
                mValue = rom[mAddr];
                mValid = 1;
                mBusy  = 0;
            end
        end else if (mEvent || mPend) begin
            mAddr   = nextAddr(mAddr);
            mDoneAt = mCyc + LAT;
            mBusy   = 1;
            mPend   = 0;
        end
    end

    task automatic clearStrobes();
        tick = 0; step = 0; restart = 0;
    endtask

    task automatic test_reset();
        rst = 1; run = 0; dir = 0; lo = 0; hi = 15; clearStrobes();
        repeat (2) @(negedge clk);
        checks++;
        if ({rom_addr, value, value_valid, busy} !== {4'd0, 16'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_state got addr=%0d value=%h valid=%b busy=%b want 0 0000 0 1",
                     rom_addr, value, value_valid, busy);
        end
        rst = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if ({rom_addr, value, value_valid, busy} !== {mAddr, mValue, mValid, mBusy}) begin
                errors++;
                $display("[TB] FAIL prime_model k=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         k, rom_addr, value, value_valid, busy, mAddr, mValue, mValid, mBusy);
            end
            checks++;
            if (value_valid !== (k == 3) || busy !== (k < 3) || value !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL prime_timing k=%0d got valid=%b busy=%b value=%h want valid=%b busy=%b value=0000",
                         k, value_valid, busy, value, (k == 3), (k < 3));
            end
        end
    endtask

    task automatic test_ascending();
        int nCap = 0;
        run = 1; dir = 0; lo = 0; hi = 15;
        for (int t = 0; t < 16; t++) begin
            for (int c = 0; c < 8; c++) begin
                tick = (c == 0);
                @(negedge clk);
                clearStrobes();
                checks++;
                if ({rom_addr, value, value_valid, busy} !== {mAddr, mValue, mValid, mBusy}) begin
                    errors++;
                    $display("[TB] FAIL ascending got %h/%h/%b/%b want %h/%h/%b/%b",
                             rom_addr, value, value_valid, busy, mAddr, mValue, mValid, mBusy);
                end
                if (value_valid) nCap++;
                if (value_valid && rom_addr == 4'd15) begin
                    checks++;
                    if (value !== 16'h0008) begin
                        errors++;
                        $display("[TB] FAIL gray15 got %h want 0008", value);
                    end
                end
            end
        end
        checks++;
        if (nCap != 16 || rom_addr !== 4'd0) begin
            errors++;
            $display("[TB] FAIL ascending_wrap got captures=%0d addr=%0d want 16 0", nCap, rom_addr);
        end
        run = 0;
    endtask

    task automatic test_descending();
        logic [3:0] exp1 [5] = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd6};
        logic [3:0] exp2 [4] = '{4'd5, 4'd4, 4'd3, 4'd4};
        run = 0; dir = 1; lo = 3; hi = 6;
        restart = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clearStrobes();
        end
        for (int s = 0; s < 9; s++) begin
            if (s == 5) hi = 4;
            step = 1;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                clearStrobes();
                checks++;
                if ({rom_addr, value, value_valid, busy} !== {mAddr, mValue, mValid, mBusy}) begin
                    errors++;
                    $display("[TB] FAIL descending got %h/%h/%b/%b want %h/%h/%b/%b",
                             rom_addr, value, value_valid, busy, mAddr, mValue, mValid, mBusy);
                end
            end
            checks++;
            if (rom_addr !== ((s < 5) ? exp1[s] : exp2[s-5])) begin
                errors++;
                $display("[TB] FAIL desc_seq s=%0d got addr=%0d want %0d",
                         s, rom_addr, (s < 5) ? exp1[s] : exp2[s-5]);
            end
        end
    endtask

    task automatic test_overlap();
        logic [15:0] masks [3] = '{16'b11, 16'b10011, 16'b111};
        logic        runs  [3] = '{1'b0, 1'b0, 1'b1};
        int          wantN [3] = '{2, 3, 2};
        dir = 0; lo = 0; hi = 15;
        for (int sc = 0; sc < 3; sc++) begin
            int nCap = 0;
            run = runs[sc];
            for (int c = 0; c < 16; c++) begin
                tick = runs[sc] & masks[sc][c];
                step = ~runs[sc] & masks[sc][c];
                @(negedge clk);
                clearStrobes();
                checks++;
                if ({rom_addr, value, value_valid, busy} !== {mAddr, mValue, mValid, mBusy}) begin
                    errors++;
                    $display("[TB] FAIL overlap sc=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                             sc, rom_addr, value, value_valid, busy, mAddr, mValue, mValid, mBusy);
                end
                if (value_valid) nCap++;
            end
            checks++;
            if (nCap != wantN[sc]) begin
                errors++;
                $display("[TB] FAIL overlap_count sc=%0d got %0d want %0d", sc, nCap, wantN[sc]);
            end
        end
        run = 0;
    endtask

    task automatic test_restart();
        int nCap = 0;
        run = 0; dir = 0; lo = 8; hi = 15;
        restart = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clearStrobes();
        end
        step = 1;
        @(negedge clk);
        clearStrobes();
        checks++;
        if (rom_addr !== 4'd9 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_setup got addr=%0d busy=%b want 9 1", rom_addr, busy);
        end
        lo = 2; restart = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            clearStrobes();
            checks++;
            if (value_valid !== (k == 2) || {rom_addr, value, busy} !== {mAddr, mValue, mBusy}) begin
                errors++;
                $display("[TB] FAIL restart_abort k=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         k, rom_addr, value, value_valid, busy, mAddr, mValue, (k == 2), mBusy);
            end
        end
        checks++;
        if (value !== 16'h0003) begin
            errors++;
            $display("[TB] FAIL restart_value got %h want 0003", value);
        end
        lo = 5; run = 1; tick = 1; restart = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            clearStrobes();
            if (value_valid) nCap++;
        end
        checks++;
        if (nCap != 1 || rom_addr !== 4'd5 || value !== rom[5]) begin
            errors++;
            $display("[TB] FAIL restart_priority got captures=%0d addr=%0d value=%h want 1 5 %h",
                     nCap, rom_addr, value, rom[5]);
        end
        run = 0;
    endtask

    task automatic test_reset_mid();
        step = 1;
        @(negedge clk);
        clearStrobes();
        rst = 1;
        @(negedge clk);
        checks++;
        if ({value, busy, value_valid} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_mid got value=%h busy=%b valid=%b want 0000 1 0",
                     value, busy, value_valid);
        end
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({rom_addr, value, value_valid, busy} !== {mAddr, mValue, mValid, mBusy}) begin
                errors++;
                $display("[TB] FAIL reset_mid_prime got %h/%h/%b/%b want %h/%h/%b/%b",
                         rom_addr, value, value_valid, busy, mAddr, mValue, mValid, mBusy);
            end
        end
    endtask

    task automatic test_invalid_range();
        int nCap = 0;
        lo = 10; hi = 4; run = 1;
        for (int t = 0; t < 5; t++) begin
            dir = 1'($urandom);
            for (int c = 0; c < 4; c++) begin
                tick = (c == 0);
                @(negedge clk);
                clearStrobes();
                if (value_valid) begin
                    nCap++;
                    checks++;
                    if (rom_addr !== 4'd10 || value !== rom[10]) begin
                        errors++;
                        $display("[TB] FAIL invalid_range got addr=%0d value=%h want 10 %h",
                                 rom_addr, value, rom[10]);
                    end
                end
            end
        end
        checks++;
        if (nCap != 5) begin
            errors++;
            $display("[TB] FAIL invalid_count got %0d want 5", nCap);
        end
        run = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            run     = ($urandom_range(0, 3) != 0) ? run : ~run;
            tick    = ($urandom_range(0, 3) == 0);
            step    = ($urandom_range(0, 3) == 0);
            restart = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 31) == 0) lo = 4'($urandom);
            if ($urandom_range(0, 31) == 0) hi = 4'($urandom);
            @(negedge clk);
            checks++;
            if ({rom_addr, value, value_valid, busy} !== {mAddr, mValue, mValid, mBusy}) begin
                errors++;
                $display("[TB] FAIL random c=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                         c, rom_addr, value, value_valid, busy, mAddr, mValue, mValid, mBusy);
            end
        end
        rst = 0;
        clearStrobes();
    endtask

    initial begin
        rst = 1; run = 0; dir = 0; lo = 0; hi = 15;
        clearStrobes();
        test_reset();
        test_ascending();
        test_descending();
        test_overlap();
        test_restart();
        test_reset_mid();
        test_invalid_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_sequencer.md
# rom_sequencer

Controller that sequences the synchronous display-pattern ROM (e.g. the 16-entry Gray-code table) and hands each fetched word to the four-digit hex display path. It turns a slow step tick, a run/pause level, manual single-step and restart strobes, a direction bit and runtime loop bounds into ROM addresses. It hides the ROM read latency and holds the last fetched word stable for the hex-to-segment converters. It sits between the clock-divider enable and the ROM/hex2seg/shownumber chain, and replaces the free-running address counter.

## Interface
- ADDR_W, 4, ROM address width
- DATA_W, 16, ROM word width (four hex digits)
- ROM_LAT, 2, clock edges from a `rom_addr` change to `rom_q` valid; legal range 1..7
- clk  in  1  system clock; single clock domain, all logic on posedge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle step enable from the divider; honoured only when `run`=1
- run  in  1  level; 1 = auto-advance on `tick`, 0 = paused
- step  in  1  one-cycle manual advance; honoured only when `run`=0
- restart  in  1  one-cycle strobe: jump to `lo`
- dir  in  1  0 = ascending, 1 = descending
- lo  in  ADDR_W  lower loop bound, inclusive
- hi  in  ADDR_W  upper loop bound, inclusive
- rom_addr  out  ADDR_W  registered address to the ROM
- rom_q  in  DATA_W  ROM read data
- value  out  DATA_W  last captured word, to hex2seg
- value_valid  out  1  one-cycle pulse when `value` updates
- busy  out  1  high while a fetch is in flight (PRIME or FETCH)

## Operation
- The FSM has three states: PRIME, FETCH and IDLE.
- Reset values: state=PRIME, `rom_addr`=0, `value`=0, `value_valid`=0, `busy`=1, pending=0, latency counter=0.
- PRIME, on the first edge with `rst`=0: `rom_addr`←`lo`, counter←ROM_LAT, go to FETCH.
- FETCH: the counter decrements each edge. On the edge where the counter equals 1: `value`←`rom_q`, `value_valid`←1 for the next cycle, go to IDLE.
- IDLE: an advance is taken when `event` = (`run`&`tick`) | (~`run`&`step`) | pending.
  - On an advance: `rom_addr`←next, counter←ROM_LAT, pending←0, go to FETCH.
- Events arriving during PRIME or FETCH set a single pending flag. Further events before the flag is consumed are dropped.
- Next address when `lo` ≤ `hi`:
  - `dir`=0: if `rom_addr` ≥ `hi`, go to `lo`; otherwise `rom_addr`+1.
  - `dir`=1: if `rom_addr` ≤ `lo`, go to `hi`; otherwise `rom_addr`−1.
  - This rule also covers an address stranded outside the range after the bounds change.
- When `lo` > `hi` (invalid range): the next address is always `lo`.
- When `lo` = `hi`: every advance refetches the same address, and `value_valid` still pulses.
- Restart, in any non-reset state: `rom_addr`←`lo`, counter←ROM_LAT, pending←0, go to FETCH. Any in-flight fetch is aborted with no `value_valid` for it.
  - Restart has priority over a simultaneous event; that event is discarded.
- `rst` has priority over everything. Reset mid-FETCH discards the fetch: no `value_valid` pulse, and `value` returns to 0.
- `value` changes only on a capture edge. It is stable between captures for display multiplexing.
- Address arithmetic is ADDR_W bits, unsigned. No wrap past 0 or 2^ADDR_W−1 occurs, because the bounds clamp first.

## Timing
- Advance accepted at edge E (IDLE):
  - `rom_addr` is new after E.
  - Capture at edge E+ROM_LAT.
  - `value_valid` is high in the cycle after E+ROM_LAT.
  - Back in IDLE after E+ROM_LAT; the next advance can be accepted at edge E+ROM_LAT+1.
- After reset release, the first `value_valid` appears after edge 1+ROM_LAT, counted from the first edge with `rst`=0.
- Maximum throughput is one word per ROM_LAT+1 cycles.
- `busy`=1 exactly while the state is PRIME or FETCH. `busy` and `value_valid` are never high in the same cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset/prime:** `lo`=0, `hi`=15, `run`=0, ROM[i]=i^(i>>1) → `value`=0x0000 with a single `value_valid` 3 cycles after reset release (ROM_LAT=2); `busy` high in the 2 preceding cycles.
- **Ascending wrap:** `run`=1, `tick` every 8 cycles, `dir`=0 → `rom_addr` goes 0,1,…,15,0; `value` tracks the Gray code (addr 15 → 0x0008).
- **Descending sub-range:** `lo`=3, `hi`=6, `dir`=1, starting at 3 → addresses 6,5,4,3,6. Then set `hi`=4 while at 6 → next address is 5, then 4, 3, 4.
- **Overlap and priority:**
  - Two `step` pulses 1 cycle apart with `run`=0 → exactly two fetches back-to-back (second via pending); a third pulse during the second fetch yields a third fetch.
  - `tick` during FETCH with a second `tick` also in that FETCH → only one extra fetch.
- **Restart mid-fetch:** `restart` one cycle after an advance to addr 9, `lo`=2 → no `value_valid` for 9; `value`=ROM[2] ROM_LAT edges after the restart edge. A restart coincident with a `tick` in IDLE → only `lo` is fetched.
- **Reset mid-fetch and invalid range:**
  - `rst` asserted during FETCH → next cycle `value`=0, `busy`=1, `value_valid`=0.
  - With `lo`=10, `hi`=4 → every advance fetches addr 10.
